// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Receiver and loader state encodings plus the data/instruction delimiter.
package cpu_loader_pkg;

    localparam logic [31:0] DELIM = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LOAD_DATA,
        LOAD_INST,
        RUN
    } ld_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchroniser on the serial line.
// Emits a one-cycle BYTE_VALID after a good stop bit, FRAME_ERR_P after a bad one.
module uart_rx
    import cpu_loader_pkg::*;
#(
    parameter int T = 130
) (
    input  logic       CLK,
    input  logic       INITIALIZE_N,
    input  logic       UART_RX,
    output logic [7:0] BYTE,
    output logic       BYTE_VALID,
    output logic       FRAME_ERR_P
);

    localparam int CW = $clog2(T);
    localparam logic [CW-1:0] HALF = CW'(T / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(T - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    rx_state_t   state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    // State register; the line reads as idle-high while in reset
    always_ff @(posedge CLK) begin
        if (!INITIALIZE_N) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing: mid-bit sampling timed from the start edge
    always_comb begin
        state_d = state_q;
        sync1_d = UART_RX;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) begin
                        byte_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BYTE        = byte_q;
    assign BYTE_VALID  = valid_q;
    assign FRAME_ERR_P = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads big-endian words from the UART into data then instruction memory,
// then forwards received bytes to the core once execution starts.
module uart_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int T       = 130,
    parameter int DADDR_W = 10,
    parameter int IADDR_W = 14
) (
    input  logic               CLK,
    input  logic               INITIALIZE_N,
    input  logic               UART_RX,
    input  logic               START_EXEC,
    output logic               DMEM_WE,
    output logic [DADDR_W-1:0] DMEM_ADDR,
    output logic [31:0]        DMEM_WDATA,
    output logic               IMEM_WE,
    output logic [IADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]        IMEM_WDATA,
    output logic [IADDR_W:0]   INST_COUNT,
    output logic               RUN,
    output logic [7:0]         RX_BYTE,
    output logic               RX_VALID,
    output logic               FRAME_ERR,
    output logic               LOAD_ERR
);

    localparam logic [DADDR_W-1:0] D_ONE = DADDR_W'(1);
    localparam logic [IADDR_W-1:0] I_ONE = IADDR_W'(1);
    localparam logic [IADDR_W:0]   C_ONE = (IADDR_W + 1)'(1);

    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ferr;

    uart_rx #(
        .T(T)
    ) u_rx (
        .CLK         (CLK),
        .INITIALIZE_N(INITIALIZE_N),
        .UART_RX     (UART_RX),
        .BYTE        (b_data),
        .BYTE_VALID  (b_valid),
        .FRAME_ERR_P (b_ferr)
    );

    ld_state_t          state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [DADDR_W-1:0] dptr_q, dptr_d;
    logic [IADDR_W-1:0] iptr_q, iptr_d;
    logic               dfull_q, dfull_d;
    logic               ifull_q, ifull_d;
    logic [IADDR_W:0]   icnt_q, icnt_d;
    logic               dwe_q, dwe_d;
    logic [DADDR_W-1:0] daddr_q, daddr_d;
    logic [31:0]        dwdata_q, dwdata_d;
    logic               iwe_q, iwe_d;
    logic [IADDR_W-1:0] iaddr_q, iaddr_d;
    logic [31:0]        iwdata_q, iwdata_d;
    logic               ferr_q, ferr_d;
    logic               lerr_q, lerr_d;

    logic [31:0] word_nx;
    logic [1:0]  bcnt_nx;
    logic        done;
    logic        running;

    // Loader registers and output flops
    always_ff @(posedge CLK) begin
        if (!INITIALIZE_N) begin
            state_q  <= LOAD_DATA;
            word_q   <= '0;
            bcnt_q   <= '0;
            dptr_q   <= '0;
            iptr_q   <= '0;
            dfull_q  <= 1'b0;
            ifull_q  <= 1'b0;
            icnt_q   <= '0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            iwe_q    <= 1'b0;
            iaddr_q  <= '0;
            iwdata_q <= '0;
            ferr_q   <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            bcnt_q   <= bcnt_d;
            dptr_q   <= dptr_d;
            iptr_q   <= iptr_d;
            dfull_q  <= dfull_d;
            ifull_q  <= ifull_d;
            icnt_q   <= icnt_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            iwe_q    <= iwe_d;
            iaddr_q  <= iaddr_d;
            iwdata_q <= iwdata_d;
            ferr_q   <= ferr_d;
            lerr_q   <= lerr_d;
        end
    end

    // Word assembly, memory routing and the start-of-execution handover
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        bcnt_d   = bcnt_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        dfull_d  = dfull_q;
        ifull_d  = ifull_q;
        icnt_d   = icnt_q;
        dwe_d    = 1'b0;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        iwe_d    = 1'b0;
        iaddr_d  = iaddr_q;
        iwdata_d = iwdata_q;
        ferr_d   = ferr_q | b_ferr;
        lerr_d   = lerr_q;

        running = (state_q == cpu_loader_pkg::RUN);
        word_nx = {word_q[23:0], b_data};
        bcnt_nx = b_valid ? bcnt_q + 2'd1 : bcnt_q;
        done    = b_valid && (bcnt_q == 2'd3);

        if (b_valid && !running) begin
            word_d = word_nx;
            bcnt_d = bcnt_nx;
        end

        unique case (state_q)
            LOAD_DATA: begin
                if (done) begin
                    if (word_nx == DELIM) begin
                        state_d = LOAD_INST;
                    end else if (!dfull_q) begin
                        dwe_d    = 1'b1;
                        daddr_d  = dptr_q;
                        dwdata_d = word_nx;
                        if (dptr_q == '1) begin
                            dfull_d = 1'b1;
                            lerr_d  = 1'b1;
                        end else begin
                            dptr_d = dptr_q + D_ONE;
                        end
                    end
                end
            end
            LOAD_INST: begin
                if (done && !ifull_q) begin
                    iwe_d    = 1'b1;
                    iaddr_d  = iptr_q;
                    iwdata_d = word_nx;
                    icnt_d   = icnt_q + C_ONE;
                    if (iptr_q == '1) begin
                        ifull_d = 1'b1;
                        lerr_d  = 1'b1;
                    end else begin
                        iptr_d = iptr_q + I_ONE;
                    end
                end
                if (START_EXEC) begin
                    state_d = cpu_loader_pkg::RUN;
                    bcnt_d  = '0;
                    if (bcnt_nx != 2'd0) begin
                        lerr_d = 1'b1;
                    end
                end
            end
            cpu_loader_pkg::RUN: begin
                state_d = cpu_loader_pkg::RUN;
            end
            default: state_d = LOAD_DATA;
        endcase
    end

    assign DMEM_WE    = dwe_q;
    assign DMEM_ADDR  = daddr_q;
    assign DMEM_WDATA = dwdata_q;
    assign IMEM_WE    = iwe_q;
    assign IMEM_ADDR  = iaddr_q;
    assign IMEM_WDATA = iwdata_q;
    assign INST_COUNT = icnt_q;
    assign RUN        = running;
    assign RX_BYTE    = running ? b_data : 8'h00;
    assign RX_VALID   = running && b_valid;
    assign FRAME_ERR  = ferr_q;
    assign LOAD_ERR   = lerr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serial frames driven bit by bit,
// memory writes and forwarded bytes compared against a word-level model.
module tb_uart_program_loader;

    localparam int T    = 16;
    localparam int DW   = 3;
    localparam int IW   = 3;
    localparam int DMAX = (1 << DW) - 1;
    localparam int IMAX = (1 << IW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          rx;
    logic          start;
    logic          dwe;
    logic [DW-1:0] daddr;
    logic [31:0]   dwd;
    logic          iwe;
    logic [IW-1:0] iaddr;
    logic [31:0]   iwd;
    logic [IW:0]   icnt;
    logic          run;
    logic [7:0]    rxb;
    logic          rxv;
    logic          ferr;
    logic          lerr;

    uart_program_loader #(
        .T      (T),
        .DADDR_W(DW),
        .IADDR_W(IW)
    ) dut (
        .CLK         (clk),
        .INITIALIZE_N(rst_n),
        .UART_RX     (rx),
        .START_EXEC  (start),
        .DMEM_WE     (dwe),
        .DMEM_ADDR   (daddr),
        .DMEM_WDATA  (dwd),
        .IMEM_WE     (iwe),
        .IMEM_ADDR   (iaddr),
        .IMEM_WDATA  (iwd),
        .INST_COUNT  (icnt),
        .RUN         (run),
        .RX_BYTE     (rxb),
        .RX_VALID    (rxv),
        .FRAME_ERR   (ferr),
        .LOAD_ERR    (lerr)
    );

    int errors = 0;
    int checks = 0;

    bit [47:0] exp_d[$];
    bit [47:0] act_d[$];
    bit [47:0] exp_i[$];
    bit [47:0] act_i[$];
    bit [7:0]  exp_r[$];
    bit [7:0]  act_r[$];
    bit [7:0]  m_bytes[$];

    int m_mode;
    int m_dptr;
    int m_iptr;
    int m_icnt;
    bit m_dfull;
    bit m_ifull;
    bit m_lerr;
    bit m_ferr;

    int   wide = 0;
    logic pd = 1'b0;
    logic pi = 1'b0;
    logic pr = 1'b0;

    always @(negedge clk) begin
        if (dwe) act_d.push_back({16'(daddr), dwd});
        if (iwe) act_i.push_back({16'(iaddr), iwd});
        if (rxv) act_r.push_back(rxb);
        if ((dwe && pd) || (iwe && pi) || (rxv && pr)) wide++;
        pd = dwe;
        pi = iwe;
        pr = rxv;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_dptr  = 0;
        m_iptr  = 0;
        m_icnt  = 0;
        m_dfull = 0;
        m_ifull = 0;
        m_lerr  = 0;
        m_ferr  = 0;
        m_bytes.delete();
        exp_d.delete();
        exp_i.delete();
        exp_r.delete();
    endtask

    task automatic model_byte(input bit [7:0] b);
        bit [31:0] w;
        if (m_mode == 2) begin
            exp_r.push_back(b);
            return;
        end
        m_bytes.push_back(b);
        if (m_bytes.size() < 4) return;
        w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_bytes.delete();
        if (m_mode == 0) begin
            if (w == 32'hFFFF_FFFF) m_mode = 1;
            else if (!m_dfull) begin
                exp_d.push_back({16'(m_dptr), w});
                if (m_dptr == DMAX) begin
                    m_dfull = 1;
                    m_lerr  = 1;
                end else m_dptr++;
            end
        end else if (!m_ifull) begin
            exp_i.push_back({16'(m_iptr), w});
            m_icnt++;
            if (m_iptr == IMAX) begin
                m_ifull = 1;
                m_lerr  = 1;
            end else m_iptr++;
        end
    endtask

    task automatic model_start();
        if (m_mode == 1) begin
            if (m_bytes.size() != 0) m_lerr = 1;
            m_bytes.delete();
            m_mode = 2;
        end
    endtask

    task automatic drain();
        int n;
        @(posedge clk);
        #1;
        check("dmem_writes", act_d.size(), exp_d.size());
        n = act_d.size() < exp_d.size() ? act_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check("dmem_addr", act_d[i][47:32], exp_d[i][47:32]);
            check("dmem_data", act_d[i][31:0], exp_d[i][31:0]);
        end
        check("imem_writes", act_i.size(), exp_i.size());
        n = act_i.size() < exp_i.size() ? act_i.size() : exp_i.size();
        for (int i = 0; i < n; i++) begin
            check("imem_addr", act_i[i][47:32], exp_i[i][47:32]);
            check("imem_data", act_i[i][31:0], exp_i[i][31:0]);
        end
        check("rx_bytes", act_r.size(), exp_r.size());
        n = act_r.size() < exp_r.size() ? act_r.size() : exp_r.size();
        for (int i = 0; i < n; i++) begin
            check("rx_byte", act_r[i], exp_r[i]);
        end
        act_d.delete();
        exp_d.delete();
        act_i.delete();
        exp_i.delete();
        act_r.delete();
        exp_r.delete();
        check("inst_count", icnt, m_icnt);
        check("load_err", lerr, m_lerr);
        check("frame_err", ferr, m_ferr);
        check("run", run, m_mode == 2);
        @(negedge clk);
    endtask

    task automatic send_frame(input bit [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (T) @(negedge clk);
        end
        rx = stop;
        repeat (T) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_byte(input bit [7:0] b);
        send_frame(b, 1'b1);
        model_byte(b);
        drain();
    endtask

    task automatic send_word(input bit [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31 - 8 * k -: 8]);
        end
    endtask

    function automatic bit [31:0] rand_float();
        bit [31:0] w;
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        return w;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_dmem"}, {dwe, daddr, dwd}, 0);
        check({tag, "_imem"}, {iwe, iaddr, iwd}, 0);
        check({tag, "_misc"}, {icnt, run, rxb, rxv, ferr, lerr}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        do_reset();

        send_word(32'h3F80_0000);
        check("t2_addr0", daddr, 0);
        check("t2_data0", dwd, 32'h3F80_0000);
        send_word(32'h4000_0000);
        check("t2_addr1", daddr, 1);

        pulse_start();
        check("start_in_data_ignored", run, 1'b0);

        for (int i = 0; i < 5; i++) send_word(rand_float());
        send_word(32'hFFFF_FFFF);
        send_word(32'h4F84_E200);
        check("t3_iaddr", iaddr, 0);
        check("t3_idata", iwd, 32'h4F84_E200);
        check("t3_icount", icnt, 1);
        check("t3_daddr_last", daddr, 6);

        send_frame(8'($urandom), 1'b0);
        m_ferr = 1;
        repeat (2 * T) @(negedge clk);
        drain();
        check("t4_ferr", ferr, 1'b1);
        send_byte(8'h12);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        check("t4_iaddr", iaddr, 1);
        check("t4_idata_msb", iwd[31:24], 8'h12);

        rx = 1'b0;
        repeat (T / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * T) @(negedge clk);
        drain();
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        pulse_start();
        check("t5_run", run, 1'b1);
        check("t5_lerr", lerr, 1'b1);
        drain();

        send_byte(8'hA5);
        send_byte(8'h3C);
        check("t1_rxbyte", rxb, 8'h3C);
        for (int i = 0; i < 2; i++) send_byte(8'($urandom));

        do_reset();
        send_word(32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) send_word($urandom);
        check("t6_icount5", icnt, 5);
        rx = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'($urandom);
            repeat (T) @(negedge clk);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check_zero("midframe");
        rst_n = 1'b1;
        model_reset();
        repeat (10 * T) @(negedge clk);
        drain();
        send_word(32'h0000_0001);
        check("t6_addr", daddr, 0);
        check("t6_data", dwd, 32'h0000_0001);

        for (int i = 0; i < 8; i++) send_word(rand_float());
        check("dmem_wrap_lerr", lerr, 1'b1);
        check("dmem_wrap_addr", daddr, DMAX);

        do_reset();
        send_word(32'hFFFF_FFFF);
        for (int i = 0; i < 9; i++) send_word($urandom);
        check("imem_wrap_count", icnt, IMAX + 1);
        check("imem_wrap_addr", iaddr, IMAX);

        check("strobe_width", wide, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Sits between the board UART_RX pin and the CPU memories. It deserialises 8N1 frames and assembles big-endian 32-bit words. Words before the 0xFFFFFFFF delimiter go to data memory (float constant table); words after it go to instruction memory. After START_EXEC it stops loading, raises RUN and forwards received bytes to the core as program input.

Parameters:
T, 130, clock cycles per UART bit (same meaning as global T; 15 MHz clock, 115200 baud)
DADDR_W, 10, data-memory address width
IADDR_W, 14, instruction-memory address width

Ports:
CLK  in  1  system clock
INITIALIZE_N  in  1  synchronous active-low reset
UART_RX  in  1  serial line, idle high, asynchronous to CLK
START_EXEC  in  1  level/pulse request to begin execution
DMEM_WE  out  1  data-memory write strobe, one cycle
DMEM_ADDR  out  DADDR_W  data-memory word address
DMEM_WDATA  out  32  data-memory write word
IMEM_WE  out  1  instruction-memory write strobe, one cycle
IMEM_ADDR  out  IADDR_W  instruction-memory word address
IMEM_WDATA  out  32  instruction word
INST_COUNT  out  IADDR_W+1  instructions loaded
RUN  out  1  high from the cycle after START_EXEC is accepted
RX_BYTE  out  8  byte forwarded in RUN
RX_VALID  out  1  one-cycle strobe with RX_BYTE, RUN only
FRAME_ERR  out  1  sticky: bad stop bit seen
LOAD_ERR  out  1  sticky: address overflow, or partial word at START_EXEC

Behaviour:
- Reset (INITIALIZE_N=0 at CLK edge): all outputs 0, including ADDRs, INST_COUNT and the sticky flags. The state machine returns to LOAD_DATA, the byte counter clears, and any receiver frame in progress is abandoned. Reset mid-frame must not emit a byte.
- RX path: UART_RX passes through a 2-flop synchroniser and is treated as 1 during reset. Receiver states are IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised falling edge.
  - START: sample at T/2. If the line is 1, treat it as a glitch and return to IDLE; if 0, go to DATA.
  - DATA: sample 8 bits every T cycles, LSB first.
  - STOP: sample at the next T. If the line is 1, byte_valid pulses the next cycle. If it is 0, set FRAME_ERR, drop the byte, and wait in IDLE for the line to return high.
  - Back-to-back frames with no idle gap must be accepted.
- Word assembly: byte_valid shifts into a 32-bit register MSB first (first byte -> [31:24]) and increments a 2-bit counter. On the 4th byte the word is complete; the write strobe appears one cycle after the 4th byte_valid.
- Loader FSM, states LOAD_DATA, LOAD_INST, RUN:
  - LOAD_DATA, word == 0xFFFFFFFF: go to LOAD_INST; no write; byte counter resets.
  - LOAD_DATA, any other word: DMEM_WE with DMEM_ADDR = current data pointer, then the pointer increments. A 0xFFFFFFFF float is therefore not loadable; this is intended.
  - LOAD_INST: every word, including 0xFFFFFFFF, is written with IMEM_WE at the current pointer. The pointer then increments and INST_COUNT increments.
  - Pointer wrap: a write while the pointer is at its maximum is performed, then LOAD_ERR is set. Further words are dropped (no strobe); the pointer does not wrap.
- START_EXEC:
  - Sampled only in LOAD_INST (ignored in LOAD_DATA and RUN). When sampled there, it moves the FSM to RUN; RUN=1 the next cycle.
  - If the byte counter is nonzero, the partial word is discarded and LOAD_ERR is set.
  - If START_EXEC and a word completion coincide in the same cycle, the word is written first, then the FSM moves to RUN.
- RUN: no memory writes. Each byte_valid drives RX_BYTE/RX_VALID (same cycle as the would-be shift); the receiver keeps running. RUN is left only by reset.
- DMEM_WDATA/IMEM_WDATA hold the last written word; ADDR outputs show the write address during the strobe.

Decomposition:
- Shared package cpu_loader_pkg:
  - DELIM = 32'hFFFF_FFFF
  - rx_state_t {IDLE, START, DATA, STOP}
  - ld_state_t {LOAD_DATA, LOAD_INST, RUN}
- Sub-module uart_rx (parameter T; ports CLK, INITIALIZE_N, UART_RX, BYTE, BYTE_VALID, FRAME_ERR_P). It contains the synchroniser and the rx FSM; uart_program_loader owns word assembly and the loader FSM.

Test Plan:
1. Frame 0xA5 (start 0, LSB first, stop 1) after the delimiter, then START_EXEC -> RUN=1; a second frame 0x3C gives RX_BYTE=0x3C with one-cycle RX_VALID, no IMEM_WE.
2. Bytes 3F 80 00 00 -> DMEM_WE one cycle after the 4th byte, DMEM_ADDR=0, DMEM_WDATA=0x3F800000. Next word 0x40000000 -> DMEM_ADDR=1.
3. 7 float words, FF FF FF FF, then 0x4F84E200 -> no write for the delimiter; IMEM_WE at IMEM_ADDR=0 with 0x4F84E200; INST_COUNT=1; DMEM pointer stays at 7.
4. Frame with stop bit 0 -> no byte_valid and FRAME_ERR=1. The following good frame 0x12 is accepted; the word counter is unaffected by the bad frame.
5. 0-pulse on UART_RX of T/4 -> no byte; receiver back in IDLE. Then START_EXEC after 2 bytes of an instruction word -> RUN=1, LOAD_ERR=1, no IMEM_WE.
6. Reset mid-frame after 4 data bits in LOAD_INST with INST_COUNT=5 -> all outputs 0, state LOAD_DATA. A fresh word 0x00000001 goes to DMEM_ADDR=0.
